// File: rtl/request_encoder.sv
// request_encoder
// ---------------
// Sequential 8-to-3 encoder. A multi-hot request word is accepted over a
// valid/ready handshake, and the 3-bit index of each set bit is emitted, one
// per accepted output beat, until the word is exhausted.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer never withdraws valid or changes
// its data while it waits for ready.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   in_valid  request word presented
//   in_ready  encoder can take a word this cycle
//   in_req    request word, bit i set means index i requested
//   out_valid out_addr holds a valid index
//   out_ready downstream consumes the beat
//   out_addr  binary index of the selected pending bit
//   out_last  current beat is the final index of the word
//   zero_seen one-cycle pulse after an all-zero word was accepted
//
// Configuration:
//   REQUEST_ENCODER_ROUND_ROBIN_EN  when defined, indices are picked by a
//   rotating search starting at a persistent pointer (ascending, wrapping
//   7->0); when undefined, the lowest pending index is always picked first.
module request_encoder #(
  parameter int WIDTH = 8,
  parameter int ADDRW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDRW-1:0] out_addr,
  output logic             out_last,
  output logic             zero_seen
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pend;
  logic [ADDRW-1:0] sel;
  logic             single;
  logic             consume;
  logic             accept;
  logic [WIDTH-1:0] pend_cleared;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
  logic [ADDRW-1:0] ptr;

  // Rotating search: first pending bit at or after ptr, wrapping around.
  always_comb begin
    logic             found;
    logic [ADDRW-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = ptr + ADDRW'(i);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest set bit win.
  always_comb begin
    sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend[i]) sel = ADDRW'(i);
    end
  end
`endif

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign single = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

  // Outputs come straight from pend/state, so out_ready cannot reach them.
  assign out_valid    = (state == EMIT);
  assign out_addr     = sel;
  assign out_last     = (state == EMIT) && single;

  assign consume      = out_valid && out_ready;
  // In EMIT a new word may only enter as the final index leaves.
  assign in_ready     = (state == IDLE) || (consume && out_last);
  assign accept       = in_valid && in_ready;
  assign pend_cleared = pend & ~(WIDTH'(1) << sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      zero_seen <= 1'b0;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else begin
      zero_seen <= 1'b0;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
      if (consume) ptr <= sel + ADDRW'(1);
`endif
      if (accept) begin
        // Covers both IDLE loads and the back-to-back load on the last beat;
        // in the latter case the cleared pend would be zero anyway.
        pend <= in_req;
        if (in_req != '0) begin
          state <= EMIT;
        end else begin
          state     <= IDLE;
          zero_seen <= 1'b1;
        end
      end else if (consume) begin
        pend <= pend_cleared;
        if (out_last) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder
// ------------------
// Bench for request_encoder. Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge. A monitor keeps an expected-beat
// queue, filled when a word is accepted and drained as beats are consumed.
module tb_request_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_req = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_addr;
  logic       out_last;
  logic       zero_seen;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_on = 1'b0;

  // Expected entries: {word[7:0], last, addr[2:0]}
  logic [11:0] exp_q[$];
  logic [2:0]  got_q[$];
  int          got_cyc[$];
  logic [2:0]  ptr_m = 3'd0;
  logic        zs_exp = 1'b0;

  request_encoder #(.WIDTH(8), .ADDRW(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_last(out_last), .zero_seen(zero_seen)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference order of indices for a word, starting from the model pointer.
  task automatic push_word(input logic [7:0] w);
    int         n;
    int         k;
    logic [2:0] p;
    logic [2:0] idx;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(w[i]);
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    p = ptr_m;
`else
    p = 3'd0;
`endif
    k = 0;
    for (int j = 0; j < 8; j++) begin
      idx = p + 3'(j);
      if (w[idx]) begin
        k++;
        exp_q.push_back({w, (k == n), idx});
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] e;
    if (reset) begin
      exp_q.delete();
      ptr_m  = 3'd0;
      zs_exp = 1'b0;
    end else begin
      check_eq("zero_seen", zero_seen, zs_exp);
      check_eq("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        check_eq("out_addr", out_addr, e[2:0]);
        check_eq("out_last", out_last, e[3]);
        check_eq("decoder", ((8'b1 << out_addr) & e[11:4]) != 8'h00, 1);
        check_eq("in_ready_emit", in_ready, e[3] & out_ready);
      end else if (!out_valid) begin
        check_eq("in_ready_idle", in_ready, 1);
      end
      // Consume before accept so a back-to-back word sees the updated pointer.
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got_q.push_back(out_addr);
        got_cyc.push_back(cyc);
        ptr_m = e[2:0] + 3'd1;
      end
      zs_exp = 1'b0;
      if (in_valid && in_ready) begin
        if (in_req == 8'h00) zs_exp = 1'b1;
        else push_word(in_req);
      end
    end
  end

  // Random backpressure for the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [7:0] w);
    int n;
    in_valid = 1'b1;
    in_req   = w;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!out_valid && !in_valid) break;
      n++;
      if (n > 400) begin
        check_eq("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
  endtask

  // Compare the consumed-index log to n packed expected indices (first in MSBs).
  task automatic check_seq(input string tag, input int n, input logic [11:0] e);
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) check_eq(tag, got_q[i], e[11 - 3*i -: 3]);
    end
  endtask

  initial begin
    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_zero_seen", zero_seen, 0);
    @(posedge clk);
    #1;

    // Full-rate word 1010_0110
    clear_log();
    out_ready = 1'b1;
    send_word(8'b1010_0110);
    wait_idle();
    check_seq("seq_a6", 4, {3'd1, 3'd2, 3'd5, 3'd7});
    if (got_cyc.size() == 4) check_eq("a6_rate", got_cyc[3] - got_cyc[0], 3);

    // Same word under backpressure
    clear_log();
    out_ready = 1'b0;
    send_word(8'b1010_0110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_addr", out_addr, 3'd1);
      check_eq("bp_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check_seq("seq_bp", 4, {3'd1, 3'd2, 3'd5, 3'd7});

    // Zero word
    send_word(8'h00);
    @(negedge clk);
    check_eq("zero_pulse", zero_seen, 1);
    check_eq("zero_valid", out_valid, 0);
    check_eq("zero_ready", in_ready, 1);
    @(negedge clk);
    check_eq("zero_clear", zero_seen, 0);
    check_eq("zero_valid2", out_valid, 0);
    @(posedge clk);
    #1;

    // Back-to-back: second word enters on the last beat of the first
    clear_log();
    send_word(8'h18);
    send_word(8'h01);
    wait_idle();
    check_seq("seq_b2b", 3, {3'd3, 3'd4, 3'd0, 3'd0});
    if (got_cyc.size() == 3) check_eq("b2b_no_bubble", got_cyc[2] - got_cyc[0], 2);

    // Pointer-dependent ordering
    clear_log();
    send_word(8'h08);
    send_word(8'h81);
    wait_idle();
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    check_seq("seq_rr", 3, {3'd3, 3'd7, 3'd0, 3'd0});
`else
    check_seq("seq_rr", 3, {3'd3, 3'd0, 3'd7, 3'd0});
`endif

    // Random words with random backpressure
    rand_on = 1'b1;
    for (int i = 0; i < 12; i++) send_word(8'($urandom_range(0, 255)));
    rand_on = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a word
    send_word(8'hFF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("no_residual", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
